// File: rtl/if_fetch.sv
// Instruction-fetch stage: reads four bytes per instruction over a byte-wide
// memory port, assembles them little-endian and hands {pc, inst} to IF/ID.
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_addr_i,
  input  logic [7:0]        mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic              if_valid_o,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_B0   = 3'd0,
    S_B1   = 3'd1,
    S_B2   = 3'd2,
    S_B3   = 3'd3,
    S_B4   = 3'd4,
    S_LAST = 3'd5,
    S_HOLD = 3'd6
  } state_t;

  // Handshake: if_valid_o marks {if_pc_o, if_inst_o} as presented; the word is
  // consumed on a rising edge in S_HOLD where stall_i is low, and is held
  // unchanged for every edge where stall_i is high.

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   mem_a_d;
  logic                mem_req_d;
  logic [23:0]         buf_q, buf_d;
  logic [ADDR_W-1:0]   if_pc_d;
  logic [31:0]         if_inst_d;
  logic                if_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_B0;
      pc_q       <= RESET_PC;
      buf_q      <= '0;
      mem_a_o    <= '0;
      mem_req_o  <= 1'b0;
      if_pc_o    <= '0;
      if_inst_o  <= '0;
      if_valid_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      mem_a_o    <= mem_a_d;
      mem_req_o  <= mem_req_d;
      if_pc_o    <= if_pc_d;
      if_inst_o  <= if_inst_d;
      if_valid_o <= if_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (branch_flag_i) begin
      state_d = S_B0;
    end else begin
      case (state_q)
        S_B0:    state_d = S_B1;
        S_B1:    state_d = S_B2;
        S_B2:    state_d = S_B3;
        S_B3:    state_d = S_B4;
        S_B4:    state_d = S_LAST;
        S_LAST:  state_d = S_HOLD;
        S_HOLD:  state_d = stall_i ? S_HOLD : S_B0;
        default: state_d = S_B0;
      endcase
    end
  end

  // Byte k is captured two edges after its address is issued, since memory
  // answers one cycle after the registered address appears.
  always_comb begin
    pc_d       = pc_q;
    mem_a_d    = mem_a_o;
    mem_req_d  = mem_req_o;
    buf_d      = buf_q;
    if_pc_d    = if_pc_o;
    if_inst_d  = if_inst_o;
    if_valid_d = if_valid_o;
    if (branch_flag_i) begin
      pc_d       = branch_target_addr_i;
      mem_req_d  = 1'b0;
      if_valid_d = 1'b0;
      buf_d      = '0;
    end else begin
      case (state_q)
        S_B0: begin
          mem_a_d   = pc_q;
          mem_req_d = 1'b1;
        end
        S_B1: mem_a_d = pc_q + ADDR_W'(1);
        S_B2: begin
          mem_a_d     = pc_q + ADDR_W'(2);
          buf_d[7:0]  = mem_din_i;
        end
        S_B3: begin
          mem_a_d     = pc_q + ADDR_W'(3);
          buf_d[15:8] = mem_din_i;
        end
        S_B4: begin
          mem_req_d    = 1'b0;
          buf_d[23:16] = mem_din_i;
        end
        S_LAST: begin
          if_inst_d  = {mem_din_i, buf_q};
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
        end
        S_HOLD: begin
          if (!stall_i) begin
            if_valid_d = 1'b0;
            pc_d       = pc_q + ADDR_W'(4);
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory model, directed scenarios plus random
// fetch/stall/redirect traffic, and a scoreboard of presented instructions.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_addr_i;
  logic [7:0]  mem_din_i = 8'h00;
  logic [31:0] mem_a_o;
  logic        mem_req_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic [2:0]  dbg_state_o;

  if_fetch #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_i              (stall_i),
    .branch_flag_i        (branch_flag_i),
    .branch_target_addr_i (branch_target_addr_i),
    .mem_din_i            (mem_din_i),
    .mem_a_o              (mem_a_o),
    .mem_req_o            (mem_req_o),
    .if_pc_o              (if_pc_o),
    .if_inst_o            (if_inst_o),
    .if_valid_o           (if_valid_o),
    .dbg_state_o          (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  always @(posedge clk) mem_din_i <= mem_rd(mem_a_o);

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_inst(input logic [31:0] p);
    return {mem_rd(p + 32'd3), mem_rd(p + 32'd2), mem_rd(p + 32'd1), mem_rd(p)};
  endfunction

  logic [31:0] model_pc;
  logic [63:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_v = 1'b0;
  logic [63:0] cur = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_v = 1'b0;
    end else begin
      if (if_valid_o && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_pc", if_pc_o, 32'hxxxx_xxxx);
        end else begin
          cur = exp_q.pop_front();
          chk("inst_pc", if_pc_o, cur[63:32]);
          chk("inst_word", if_inst_o, cur[31:0]);
        end
      end else if (if_valid_o && prev_v) begin
        chk("hold_pc", if_pc_o, cur[63:32]);
        chk("hold_word", if_inst_o, cur[31:0]);
      end
      prev_v = if_valid_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch from S_B0, then either consume or redirect from S_HOLD.
  task automatic fetch(input int stall_n, input bit redir, input logic [31:0] tgt);
    logic [31:0] p;
    int n;
    bit got;
    p = model_pc;
    exp_q.push_back({p, exp_inst(p)});
    stall_i = (stall_n > 0);
    n = 0;
    got = 1'b0;
    while (n < 12 && !got) begin
      tick();
      n++;
      if (n <= 4) begin
        chk("mem_a", mem_a_o, p + 32'(n - 1));
        chk("mem_req_on", 32'(mem_req_o), 32'd1);
      end
      if (n == 5) chk("mem_req_off", 32'(mem_req_o), 32'd0);
      if (if_valid_o) got = 1'b1;
    end
    chk("latency", 32'(n), 32'd6);
    if (got) repeat (stall_n) tick();
    if (redir) begin
      branch_flag_i = 1'b1;
      branch_target_addr_i = tgt;
      stall_i = 1'($urandom_range(0, 1));
      tick();
      branch_flag_i = 1'b0;
      chk("redir_valid_drop", 32'(if_valid_o), 32'd0);
      model_pc = tgt;
    end else begin
      stall_i = 1'b0;
      tick();
      chk("consume_valid_drop", 32'(if_valid_o), 32'd0);
      model_pc = p + 32'd4;
    end
    stall_i = 1'b0;
  endtask

  // Redirect k edges into a fetch (k=0..5), so the word is never presented.
  task automatic fetch_abort(input int k, input logic [31:0] tgt);
    stall_i = 1'($urandom_range(0, 1));
    repeat (k) tick();
    branch_flag_i = 1'b1;
    branch_target_addr_i = tgt;
    tick();
    branch_flag_i = 1'b0;
    stall_i = 1'b0;
    chk("abort_valid", 32'(if_valid_o), 32'd0);
    chk("abort_req", 32'(mem_req_o), 32'd0);
    model_pc = tgt;
  endtask

  task automatic reset_mid_fetch();
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_a", mem_a_o, 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_inst", if_inst_o, 32'd0);
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    tick();
    rst = 1'b1;
    model_pc = RESET_PC;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    logic [31:0] t;
    mem[32'h0] = 8'h93;
    mem[32'h1] = 8'h00;
    mem[32'h2] = 8'h10;
    mem[32'h3] = 8'h00;
    rst = 1'b0;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_addr_i = '0;
    model_pc = RESET_PC;
    #3;
    chk("reset_mem_a", mem_a_o, 32'd0);
    chk("reset_mem_req", 32'(mem_req_o), 32'd0);
    chk("reset_pc", if_pc_o, 32'd0);
    chk("reset_inst", if_inst_o, 32'd0);
    chk("reset_valid", 32'(if_valid_o), 32'd0);
    chk("first_word_model", exp_inst(32'h0), 32'h0010_0093);
    tick();
    rst = 1'b1;

    fetch(0, 1'b0, '0);
    fetch(10, 1'b0, '0);
    fetch_abort(3, 32'h0000_1000);
    fetch(0, 1'b0, '0);
    fetch(2, 1'b1, 32'h0000_0020);
    fetch(0, 1'b0, '0);
    fetch_abort(0, 32'hFFFF_FFFC);
    fetch(0, 1'b0, '0);
    chk("wrap_pc", model_pc, 32'h0000_0000);
    fetch(0, 1'b0, '0);
    fetch_abort(1, 32'h0000_0102);
    fetch(1, 1'b0, '0);
    reset_mid_fetch();
    fetch(0, 1'b0, '0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 5);
      t = $urandom;
      case (op)
        0, 1, 2: fetch($urandom_range(0, 3), 1'b0, '0);
        3:       fetch($urandom_range(0, 3), 1'b1, t);
        default: fetch_abort($urandom_range(0, 5), t);
      endcase
    end

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
